// File: rtl/temp_window_sequencer.sv
//==============================================================================
// Module  : temp_window_sequencer
// Brief   : Sliding-window temperature statistics (avg/min/max) over an
//           external BRAM. Optional macro TEMP_SEQ_ROUND_EN rounds the average.
// Revision: 1.0
//==============================================================================
`default_nettype none

module temp_window_sequencer #(
   parameter int DEPTH  = 10,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic              clear,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] avg_temp,
   output logic [DATA_W-1:0] max_temp,
   output logic [DATA_W-1:0] min_temp,
   output logic              stats_valid,
   output logic              busy,
   output logic [4:0]        fill_count
);

   localparam int                 c_sum_w     = DATA_W + 4;
   localparam int                 c_cnt_w     = $clog2(c_sum_w);
   localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);
   localparam logic [4:0]         c_depth     = 5'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_div_last  = c_cnt_w'(c_sum_w - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      SCAN  = 3'd2,
      DRAIN = 3'd3,
      DIV   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_accept;
   logic                w_scan_last;

   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [4:0]          r_fill_count;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_we;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_avg;
   logic [DATA_W-1:0]   r_min_out;
   logic [DATA_W-1:0]   r_max_out;
   logic                r_stats_valid;

   logic                r_rd_valid;
   logic [c_sum_w-1:0]  r_sum;
   logic [DATA_W-1:0]   r_min;
   logic [DATA_W-1:0]   r_max;
   logic [c_sum_w-1:0]  r_rem;
   logic [c_sum_w-1:0]  r_quo;
   logic [c_cnt_w-1:0]  r_div_cnt;

   logic [c_sum_w-1:0]  w_sum_acc;
   logic [DATA_W-1:0]   w_min_acc;
   logic [DATA_W-1:0]   w_max_acc;
   logic [c_sum_w-1:0]  w_dividend;
   logic [c_sum_w:0]    w_rem_shift;
   logic [c_sum_w-1:0]  w_divisor;
   logic                w_ge;
   logic [c_sum_w-1:0]  w_rem_next;
   logic [c_sum_w-1:0]  w_quo_next;

   assign sample_ready = (r_state == IDLE);
   assign busy         = (r_state != IDLE);
   assign mem_addr     = r_mem_addr;
   assign mem_we       = r_mem_we;
   assign mem_wdata    = r_mem_wdata;
   assign avg_temp     = r_avg;
   assign min_temp     = r_min_out;
   assign max_temp     = r_max_out;
   assign stats_valid  = r_stats_valid;
   assign fill_count   = r_fill_count;

   assign w_scan_last = (32'(r_mem_addr) == (32'(r_fill_count) - 32'd1));

   // Read data lags its address by one cycle, so accumulation runs one cycle behind SCAN.
   assign w_sum_acc = r_sum + c_sum_w'(mem_rdata);
   assign w_min_acc = (mem_rdata < r_min) ? mem_rdata : r_min;
   assign w_max_acc = (mem_rdata > r_max) ? mem_rdata : r_max;

`ifdef TEMP_SEQ_ROUND_EN
   assign w_dividend = w_sum_acc + c_sum_w'(r_fill_count >> 1);
`else
   assign w_dividend = w_sum_acc;
`endif

   // One restoring-division step per DIV cycle; remainder always stays below N.
   assign w_divisor   = c_sum_w'(r_fill_count);
   assign w_rem_shift = {r_rem, r_quo[c_sum_w-1]};
   assign w_ge        = (w_rem_shift >= {1'b0, w_divisor});
   assign w_rem_next  = w_ge ? (w_rem_shift[c_sum_w-1:0] - w_divisor) : w_rem_shift[c_sum_w-1:0];
   assign w_quo_next  = {r_quo[c_sum_w-2:0], w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (sample_valid) begin
               w_accept     = 1'b1;
               w_state_next = WRITE;
            end
         end
         WRITE:   w_state_next = SCAN;
         SCAN:    if (w_scan_last) w_state_next = DRAIN;
         DRAIN:   w_state_next = DIV;
         DIV:     if (r_div_cnt == c_div_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (clear) begin
         w_state_next = IDLE;
         w_accept     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_fill_count  <= '0;
         r_mem_addr    <= '0;
         r_mem_we      <= 1'b0;
         r_mem_wdata   <= '0;
         r_avg         <= '0;
         r_min_out     <= '0;
         r_max_out     <= '0;
         r_stats_valid <= 1'b0;
         r_rd_valid    <= 1'b0;
         r_sum         <= '0;
         r_min         <= '0;
         r_max         <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_div_cnt     <= '0;
      end else if (clear) begin
         r_wr_ptr      <= '0;
         r_fill_count  <= '0;
         r_mem_addr    <= '0;
         r_mem_we      <= 1'b0;
         r_mem_wdata   <= '0;
         r_avg         <= '0;
         r_min_out     <= '0;
         r_max_out     <= '0;
         r_stats_valid <= 1'b0;
         r_rd_valid    <= 1'b0;
         r_div_cnt     <= '0;
      end else begin
         r_mem_we      <= 1'b0;
         r_stats_valid <= 1'b0;
         r_rd_valid    <= (r_state == SCAN);
         if (r_rd_valid) begin
            r_sum <= w_sum_acc;
            r_min <= w_min_acc;
            r_max <= w_max_acc;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mem_addr  <= r_wr_ptr;
                  r_mem_wdata <= sample_data;
                  r_mem_we    <= 1'b1;
               end
            end
            WRITE: begin
               r_wr_ptr   <= (r_wr_ptr == c_last_addr) ? '0 : r_wr_ptr + c_addr_one;
               if (r_fill_count != c_depth) begin
                  r_fill_count <= r_fill_count + 5'd1;
               end
               r_mem_addr <= '0;
               r_sum      <= '0;
               r_min      <= '1;
               r_max      <= '0;
            end
            SCAN: begin
               if (!w_scan_last) begin
                  r_mem_addr <= r_mem_addr + c_addr_one;
               end
            end
            DRAIN: begin
               r_rem     <= '0;
               r_quo     <= w_dividend;
               r_div_cnt <= '0;
            end
            DIV: begin
               r_rem     <= w_rem_next;
               r_quo     <= w_quo_next;
               r_div_cnt <= r_div_cnt + c_cnt_one;
               if (r_div_cnt == c_div_last) begin
                  r_avg         <= w_quo_next[DATA_W-1:0];
                  r_min_out     <= r_min;
                  r_max_out     <= r_max;
                  r_stats_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_temp_window_sequencer.sv
//==============================================================================
// Module  : tb_temp_window_sequencer
// Brief   : Self-checking bench for temp_window_sequencer with a BRAM model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_temp_window_sequencer;

   localparam int DEPTH  = 10;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] sample_data = '0;
   logic              sample_valid = 1'b0;
   logic              sample_ready;
   logic              clear = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] avg_temp;
   logic [DATA_W-1:0] max_temp;
   logic [DATA_W-1:0] min_temp;
   logic              stats_valid;
   logic              busy;
   logic [4:0]        fill_count;

   temp_window_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_data (sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .clear       (clear),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .avg_temp    (avg_temp),
      .max_temp    (max_temp),
      .min_temp    (min_temp),
      .stats_valid (stats_valid),
      .busy        (busy),
      .fill_count  (fill_count)
   );

   always #5 clk = ~clk;

   // Read-first BRAM, read data one cycle after the address
   logic [DATA_W-1:0] bram [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   int cyc = 0;
   int n_writes = 0;
   int n_pulses = 0;
   int last_waddr = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) begin
         n_writes   <= n_writes + 1;
         last_waddr <= int'(mem_addr);
      end
      if (stats_valid) n_pulses <= n_pulses + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference window: plain array holding the last DEPTH samples
   int win [DEPTH];
   int mptr = 0;
   int mcnt = 0;
   int m_waddr = 0;

   function automatic void model_reset();
      mptr = 0;
      mcnt = 0;
   endfunction

   function automatic void model_push(input int v);
      m_waddr   = mptr;
      win[mptr] = v;
      mptr      = (mptr + 1) % DEPTH;
      if (mcnt < DEPTH) mcnt++;
   endfunction

   function automatic int exp_avg(input int s, input int n);
`ifdef TEMP_SEQ_ROUND_EN
      return (s + n / 2) / n;
`else
      return s / n;
`endif
   endfunction

   task automatic wait_ready(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (sample_ready) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_stats(input int acc, output int lat, output bit got);
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         if (stats_valid) begin
            got = 1'b1;
            lat = cyc - acc;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Offer one sample, record its accept cycle, return latency to stats_valid
   task automatic run_sample(input int v, output int lat);
      bit seen, got;
      int acc;
      sample_data  = DATA_W'(v);
      sample_valid = 1'b1;
      wait_ready(seen);
      check("accept", int'(seen), 1);
      acc = cyc;
      @(negedge clk);
      sample_valid = 1'b0;
      wait_stats(acc, lat, got);
      check("stats_valid seen", int'(got), 1);
      model_push(v);
   endtask

   task automatic check_stats(input string tag, input int lat, input int e_avg, input int e_min,
                              input int e_max, input int e_fill, input int e_waddr);
      check({tag, " avg"},     int'(avg_temp),   e_avg);
      check({tag, " min"},     int'(min_temp),   e_min);
      check({tag, " max"},     int'(max_temp),   e_max);
      check({tag, " fill"},    int'(fill_count), e_fill);
      check({tag, " latency"}, lat,              e_fill + 15);
      check({tag, " waddr"},   last_waddr,       e_waddr);
   endtask

   task automatic check_model(input string tag, input int lat);
      int s, mn, mx;
      s = 0; mn = 255; mx = 0;
      for (int i = 0; i < mcnt; i++) begin
         s += win[i];
         if (win[i] < mn) mn = win[i];
         if (win[i] > mx) mx = win[i];
      end
      check_stats(tag, lat, exp_avg(s, mcnt), mn, mx, mcnt, m_waddr);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " busy"},  int'(busy),        0);
      check({tag, " ready"}, int'(sample_ready), 1);
      check({tag, " we"},    int'(mem_we),      0);
      check({tag, " sv"},    int'(stats_valid), 0);
      check({tag, " avg"},   int'(avg_temp),    0);
      check({tag, " min"},   int'(min_temp),    0);
      check({tag, " max"},   int'(max_temp),    0);
      check({tag, " fill"},  int'(fill_count),  0);
   endtask

   typedef struct {
      int data;
      int sum;
      int mn;
      int mx;
      int fill;
      int waddr;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int lat, acc, viol, p0, w0, n_exp;
      bit seen, got;

      for (int k = 1; k <= 10; k++) tbl[k-1] = '{10*k, 5*k*(k+1), 10, 10*k, k, k-1};
      tbl[10] = '{200, 740, 20, 200, 10, 0};
      tbl[11] = '{0,   720, 0,  200, 10, 1};

      // Reset state
      repeat (2) @(negedge clk);
      check_zero("reset");
      check("reset addr", int'(mem_addr), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // First sample from reset
      run_sample(25, lat);
      check_stats("first", lat, 25, 25, 25, 1, 0);

      // Clear while idle
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_zero("clear idle");
      model_reset();

      // Fill, wrap and overwrite the window
      for (int i = 0; i < 12; i++) begin
         run_sample(tbl[i].data, lat);
         check_stats($sformatf("row%0d", i), lat, exp_avg(tbl[i].sum, tbl[i].fill),
                     tbl[i].mn, tbl[i].mx, tbl[i].fill, tbl[i].waddr);
      end

      // Rounding case 1,2
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      run_sample(1, lat);
      run_sample(2, lat);
      check_stats("round", lat, exp_avg(3, 2), 1, 2, 2, 1);

      // Sample held during a busy sequence is taken exactly once
      w0 = n_writes;
      sample_data  = 8'd60;
      sample_valid = 1'b1;
      wait_ready(seen);
      check("hold accept1", int'(seen), 1);
      acc = cyc;
      @(negedge clk);
      sample_data = 8'd50;
      viol = 0;
      got  = 1'b0;
      lat  = 0;
      for (int i = 0; i < 100; i++) begin
         if (stats_valid) begin
            got = 1'b1;
            lat = cyc - acc;
            break;
         end
         if (sample_ready) viol++;
         @(negedge clk);
      end
      check("hold stats1", int'(got), 1);
      model_push(60);
      check_model("hold1", lat);
      check("hold ready while busy", viol, 0);
      wait_ready(seen);
      check("hold accept2", int'(seen), 1);
      acc = cyc;
      @(negedge clk);
      sample_valid = 1'b0;
      wait_stats(acc, lat, got);
      check("hold stats2", int'(got), 1);
      model_push(50);
      check_model("hold2", lat);
      repeat (30) @(negedge clk);
      check("hold writes", n_writes - w0, 2);

      // Clear during DIV aborts without a pulse
      sample_data  = 8'd77;
      sample_valid = 1'b1;
      wait_ready(seen);
      acc = cyc;
      @(negedge clk);
      sample_valid = 1'b0;
      n_exp = (mcnt < DEPTH) ? mcnt + 1 : DEPTH;
      for (int i = 0; i < 100 && (cyc - acc) < n_exp + 6; i++) @(negedge clk);
      check("div busy", int'(busy), 1);
      p0 = n_pulses;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_zero("clear div");
      repeat (30) @(negedge clk);
      check("clear div pulses", n_pulses - p0, 0);
      model_reset();
      run_sample(33, lat);
      check_model("after clear", lat);

      // Asynchronous reset mid-sequence
      sample_data  = 8'd88;
      sample_valid = 1'b1;
      wait_ready(seen);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      p0 = n_pulses;
      #2 rst_n = 1'b0;
      #1;
      check("async rst busy", int'(busy), 0);
      check("async rst fill", int'(fill_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check("async rst pulses", n_pulses - p0, 0);
      model_reset();
      run_sample(99, lat);
      check_model("after rst", lat);

      // Randomized samples against the window model
      for (int i = 0; i < 40; i++) begin
         run_sample(int'($urandom_range(0, 255)), lat);
         check_model($sformatf("rand%0d", i), lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/temp_window_sequencer.md
TEMP_WINDOW_SEQUENCER -- requirements
Module: temp_window_sequencer

Interface
REQ-001 Parameter DEPTH, default 10, sets the number of window entries; legal range is 2..16.
REQ-002 Parameter DATA_W, default 8, sets the sample width in bits.
REQ-003 Parameter ADDR_W, default 4, sets the memory address width; it SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  in  1  single clock; all logic is on posedge clk.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 sample_data  in  DATA_W  new temperature sample, unsigned.
REQ-007 sample_valid  in  1  sample_data is valid; the source SHALL hold sample_data until it is accepted.
REQ-008 sample_ready  out  1  high only in state IDLE; a sample is accepted when sample_valid and sample_ready are both high.
REQ-009 clear  in  1  synchronous window flush.
REQ-010 mem_addr  out  ADDR_W  external BRAM address, registered.
REQ-011 mem_we  out  1  external BRAM write enable, registered.
REQ-012 mem_wdata  out  DATA_W  external BRAM write data, registered.
REQ-013 mem_rdata  in  DATA_W  external BRAM read data, valid 1 cycle after mem_addr.
REQ-014 avg_temp, max_temp, min_temp  out  DATA_W each  window statistics, registered.
REQ-015 stats_valid  out  1  one-cycle pulse when the statistics update.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 fill_count  out  5  number of valid entries, 0..DEPTH.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, SCAN, DRAIN, DIV and DONE, and SHALL advance one state per clock unless stated otherwise.
REQ-019 IDLE to WRITE on accept (cycle T); the sample is captured into mem_wdata, and mem_addr is loaded from wr_ptr.
REQ-020 WRITE (T+1): mem_we is 1; wr_ptr increments and wraps from DEPTH-1 to 0; fill_count saturates at DEPTH; the state then goes to SCAN.
REQ-021 SCAN: mem_we is 0 and mem_addr steps 0..N-1, one address per cycle, where N is the updated fill_count; the state goes to DRAIN after address N-1.
REQ-022 Accumulation pipeline: each mem_rdata returned 1 cycle after its address updates sum, min and max.
- sum is DATA_W+4 bits and never overflows.
- At scan start: sum = 0, run_min = all ones, run_max = 0.
REQ-023 DRAIN SHALL accumulate the last read word, then go to DIV.
REQ-024 DIV: a restoring divider computes sum / N in exactly DATA_W+4 cycles (12 at default), with truncating quotient, then goes to DONE.
REQ-025 DONE: avg_temp, min_temp and max_temp load; stats_valid = 1 for this one cycle; the state then returns to IDLE.
REQ-026 Latency: stats_valid SHALL be high exactly N+15 cycles after the accept cycle at default parameters (16 for the first sample, 25 with a full window).
REQ-027 sample_valid while busy SHALL have no effect; the sample is taken when the FSM returns to IDLE.
REQ-028 clear has priority in every state:
- Next state is IDLE; wr_ptr, fill_count and all statistics outputs go to 0.
- mem_we goes to 0; stats_valid is not pulsed for an aborted sequence.
- The sample in flight is discarded.
REQ-029 With a full window, a new sample SHALL overwrite the oldest entry (address wr_ptr).
REQ-030 Statistics outputs SHALL hold their values between DONE cycles.

Reset
REQ-031 While rst_n is low: state = IDLE; wr_ptr, fill_count, mem_addr, mem_wdata, mem_we, avg_temp, max_temp, min_temp and stats_valid are all 0; internal sum and divider state are 0.
REQ-032 rst_n asserted mid-sequence SHALL abort immediately with no stats_valid pulse; the first accept after release starts with fill_count 0.

Configuration
REQ-033 Macro TEMP_SEQ_ROUND_EN:
- Defined: the divider dividend is sum + (N >> 1), so avg_temp rounds to nearest.
- Undefined: avg_temp is the truncated quotient.
- Latency is identical in both cases.

Verification
REQ-034 Reset, then accept sample 25 -> 16 cycles later stats_valid = 1 with avg = min = max = 25 and fill_count = 1.
REQ-035 Accept 10,20,...,100 -> after the 10th: avg 55, min 10, max 100, fill_count 10, stats_valid 25 cycles after the accept.
REQ-036 Continue with sample 200 -> addr 0 is overwritten; avg 74, min 20, max 200; wr_ptr wraps to 1.
REQ-037 From reset accept 1 then 2 -> avg 1 without TEMP_SEQ_ROUND_EN, avg 2 with it.
REQ-038 Hold sample_valid with sample 50 during a scan -> sample_ready stays 0 until IDLE; 50 is accepted exactly once.
REQ-039 Assert clear in DIV -> next cycle IDLE and all outputs 0; no stats_valid pulse; the following sample yields fill_count 1.
